// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate response checker: FSM state encoding and
// truth tables for the common lab gates.
package gate_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bit i of each table is the expected gate output for input vector i.
    localparam logic [1:0] TT_NOT   = 2'b01;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_response_checker.sv
// Walks every input vector of a combinational gate, holds it for SETTLE cycles,
// samples the gate output and scores it against a parameterised truth table.
module gate_response_checker
    import gate_test_pkg::*;
#(
    parameter int                  N_IN   = 1,
    parameter logic [2**N_IN-1:0]  TRUTH  = 2'b01,
    parameter int                  SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);

    localparam int              CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = {N_IN{1'b1}};
    localparam logic [N_IN:0]   ERR_MAX     = (N_IN + 1)'(2 ** N_IN);

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic             mismatch;

    always_comb begin
        mismatch = (dut_out != TRUTH[vec_out]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            vec_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_WAIT;
                        settle_cnt <= '0;
                        vec_out    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                    end
                end

                ST_WAIT: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
                        // Only the first failing vector of a run is kept.
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= vec_out;
                        end
                    end
                    if (vec_out == VEC_LAST) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        state      <= ST_WAIT;
                        vec_out    <= vec_out + 1'b1;
                        settle_cnt <= '0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench: stimulus queues the expected end-of-run result, monitors
// pop and compare whenever a checker raises done.
module tb_gate_response_checker;
    import gate_test_pkg::*;

    typedef struct {
        logic       pass;
        int         err;
        logic       fv;
        int         fvec;
        int         lat;
        int         lastvec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // DUT 1: default NOT configuration
    logic       start1 = 1'b0;
    logic       mode1  = 1'b0;          // 0 = ideal NOT, 1 = stuck at 0
    logic       dout1;
    logic [0:0] vec1;
    logic       busy1, done1, pass1, fv1;
    logic [1:0] err1;
    logic [0:0] fvec1;
    assign dout1 = mode1 ? 1'b0 : ~vec1[0];

    gate_response_checker u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_out(dout1),
        .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1)
    );

    // DUT 2: expects AND2, fed by an OR gate
    logic       start2 = 1'b0;
    logic       dout2;
    logic [1:0] vec2;
    logic       busy2, done2, pass2, fv2;
    logic [2:0] err2;
    logic [1:0] fvec2;
    assign dout2 = |vec2;

    gate_response_checker #(.N_IN(2), .TRUTH(TT_AND2), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .dut_out(dout2),
        .vec_out(vec2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_valid(fv2), .fail_vec(fvec2)
    );

    exp_t q1[$];
    exp_t q2[$];
    int   start_cyc1 = 0, start_cyc2 = 0;

    // Monitor 1
    logic done1_q = 1'b0;
    int   prev1 = 0, last1 = 0;
    logic order1 = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (done1 && !done1_q) begin
            if (q1.size() == 0) chk("d1_unexpected_done", 1, 0);
            else begin
                e = q1.pop_front();
                chk("d1_pass", int'(pass1), int'(e.pass));
                chk("d1_err_count", int'(err1), e.err);
                chk("d1_fail_valid", int'(fv1), int'(e.fv));
                chk("d1_fail_vec", int'(fvec1), e.fvec);
                chk("d1_latency", cyc - start_cyc1, e.lat);
                chk("d1_vec_order", int'(order1), 1);
                chk("d1_last_vec", last1, e.lastvec);
            end
        end
        if (!busy1) begin
            order1 = 1'b1;
            prev1  = 0;
        end else begin
            if (int'(vec1) != prev1 && int'(vec1) != prev1 + 1) order1 = 1'b0;
            prev1 = int'(vec1);
            last1 = int'(vec1);
        end
        done1_q = done1;
    end

    // Monitor 2
    logic done2_q = 1'b0;
    int   prev2 = 0, last2 = 0;
    logic order2 = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (done2 && !done2_q) begin
            if (q2.size() == 0) chk("d2_unexpected_done", 1, 0);
            else begin
                e = q2.pop_front();
                chk("d2_pass", int'(pass2), int'(e.pass));
                chk("d2_err_count", int'(err2), e.err);
                chk("d2_fail_valid", int'(fv2), int'(e.fv));
                chk("d2_fail_vec", int'(fvec2), e.fvec);
                chk("d2_latency", cyc - start_cyc2, e.lat);
                chk("d2_vec_order", int'(order2), 1);
                chk("d2_last_vec", last2, e.lastvec);
            end
        end
        if (!busy2) begin
            order2 = 1'b1;
            prev2  = 0;
        end else begin
            if (int'(vec2) != prev2 && int'(vec2) != prev2 + 1) order2 = 1'b0;
            prev2 = int'(vec2);
            last2 = int'(vec2);
        end
        done2_q = done2;
    end

    function automatic exp_t mk(input logic p, input int err, input logic fv,
                                input int fvec, input int lat, input int lastvec);
        exp_t e;
        e.pass = p; e.err = err; e.fv = fv; e.fvec = fvec; e.lat = lat; e.lastvec = lastvec;
        return e;
    endfunction

    task automatic go1();
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        #1 start_cyc1 = cyc;
        start1 = 1'b0;
    endtask

    task automatic go2();
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start_cyc2 = cyc;
        start2 = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((q1.size() != 0 || q2.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk(name, q1.size() + q2.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outputs_d1", int'({vec1, busy1, done1, pass1, err1, fv1, fvec1}), 0);
        chk("rst_outputs_d2", int'({vec2, busy2, done2, pass2, err2, fv2, fvec2}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ideal NOT
        mode1 = 1'b0;
        q1.push_back(mk(1'b1, 0, 1'b0, 0, 6, 1));
        go1();
        chk("d1_busy_after_start", int'(busy1), 1);
        drain("drain_ideal");

        // Stuck-at-0
        mode1 = 1'b1;
        q1.push_back(mk(1'b0, 1, 1'b1, 0, 6, 1));
        go1();
        drain("drain_stuck");

        // Restart from DONE with the ideal model
        mode1 = 1'b0;
        q1.push_back(mk(1'b1, 0, 1'b0, 0, 6, 1));
        go1();
        chk("restart_done_clr", int'(done1), 0);
        chk("restart_err_clr", int'(err1), 0);
        chk("restart_fv_clr", int'(fv1), 0);
        drain("drain_restart");

        // AND2 checker facing an OR gate
        q2.push_back(mk(1'b0, 2, 1'b1, 1, 12, 3));
        go2();
        drain("drain_and_or");

        // Start re-pulsed while busy
        q1.push_back(mk(1'b1, 0, 1'b0, 0, 6, 1));
        go1();
        @(negedge clk);
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        drain("drain_busy_start");

        // Async reset during WAIT of vector 1
        go1();
        begin
            int t = 0;
            while (!(busy1 && vec1 == 1'b1) && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("reach_vec1_wait", int'(busy1 && vec1 == 1'b1), 1);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", int'({vec1, busy1, done1, pass1, err1, fv1, fvec1}), 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        q1.push_back(mk(1'b1, 0, 1'b0, 0, 6, 1));
        go1();
        drain("drain_after_reset");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
